// File: rtl/bs_pkg.sv
// Shared definitions for the bus generator/arbiter.
//   ID_W       : width of the destination-ID header field
//   lane_st_e  : per-lane arbitration state
//   dest_id()  : extracts the destination ID from the top ID_W bits of a packet
package bs_pkg;

  localparam int unsigned ID_W     = 8;
  localparam int unsigned PCKG_MAX = 1024;

  typedef enum logic [1:0] {IDLE, POP, PUSH} lane_st_e;

  // Packets are passed zero-extended to PCKG_MAX; sz is the real packet width.
  function automatic logic [ID_W-1:0] dest_id(input logic [PCKG_MAX-1:0] pkt,
                                              input int unsigned         sz);
    return pkt[sz-1 -: ID_W];
  endfunction

endpackage

// File: rtl/bs_rbtr_lane.sv
// One bus lane: round-robin grant, one-cycle pop, packet latch, one-cycle push.
// Macro: BS_BROADCAST_SELF_EN -- when defined, broadcast also pushes to the source.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   pndng      : per-node FIFO non-empty
//   D_pop      : per-node FIFO head packet
//   pop        : one-cycle read strobe toward the granted node
//   push       : one-cycle write strobe(s) toward destination node(s)
//   D_push     : packet presented to all nodes of this lane
module bs_rbtr_lane
  import bs_pkg::*;
#(
  parameter int unsigned     drvrs     = 4,
  parameter int unsigned     pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [pckg_sz-1:0]              D_push
);

  localparam int unsigned SW = (drvrs > 1) ? $clog2(drvrs) : 1;

  lane_st_e           r_st, w_st_nxt;
  logic [SW-1:0]      r_last, r_src, w_sel;
  logic               w_any;
  int unsigned        w_idx;
  logic [pckg_sz-1:0] r_pkt, r_dpush;
  logic [ID_W-1:0]    w_dst;
  logic               w_ucast, w_bcast, w_dst_ok;

  // Round-robin: first pending node searching upward from the one after r_last.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_last;
    w_idx = 0;
    for (int unsigned i = 1; i <= drvrs; i++) begin
      w_idx = (int'(r_last) + i) % drvrs;
      if (!w_any && pndng[w_idx]) begin
        w_any = 1'b1;
        w_sel = SW'(w_idx);
      end
    end
  end

  assign w_dst    = dest_id(PCKG_MAX'(r_pkt), pckg_sz);
  assign w_ucast  = (int'(w_dst) < drvrs);
  assign w_bcast  = !w_ucast && (w_dst == broadcast);
  assign w_dst_ok = w_ucast || w_bcast;

  always_comb begin
    w_st_nxt = r_st;
    pop      = '0;
    push     = '0;
    unique case (r_st)
      IDLE: if (w_any) w_st_nxt = POP;
      POP: begin
        pop[r_src] = 1'b1;
        w_st_nxt   = PUSH;
      end
      PUSH: begin
        if (w_ucast) begin
          push[w_dst[SW-1:0]] = 1'b1;
        end else if (w_bcast) begin
          push = '1;
`ifdef BS_BROADCAST_SELF_EN
          push[r_src] = 1'b1;
`else
          push[r_src] = 1'b0;
`endif
        end
        w_st_nxt = IDLE;
      end
      default: w_st_nxt = IDLE;
    endcase
  end

  // Latched packet appears on D_push during PUSH; r_dpush keeps the last
  // delivered one so a dropped packet never shows up afterwards.
  assign D_push = (r_st == PUSH && w_dst_ok) ? r_pkt : r_dpush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st    <= IDLE;
      r_last  <= SW'(drvrs - 1);
      r_src   <= '0;
      r_pkt   <= '0;
      r_dpush <= '0;
    end else begin
      r_st <= w_st_nxt;
      if (r_st == IDLE && w_any) begin
        r_src  <= w_sel;
        r_last <= w_sel;
      end
      if (r_st == POP) r_pkt <= D_pop[r_src];
      if (r_st == PUSH && w_dst_ok) r_dpush <= r_pkt;
    end
  end

endmodule

// File: rtl/bus_gnrtr_n_rbtr.sv
// Shared-bus generator and arbiter: `bits` independent lanes of `drvrs` nodes,
// each lane popping one packet at a time and pushing it to its destination.
// Macro: BS_BROADCAST_SELF_EN -- when defined, broadcast also pushes to the source.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   pndng      : [bits][drvrs] node FIFO non-empty
//   push       : [bits][drvrs] one-cycle write strobe into node
//   pop        : [bits][drvrs] one-cycle read strobe from node FIFO
//   D_pop      : [pckg_sz][bits][drvrs] node FIFO head packet
//   D_push     : [pckg_sz][bits][drvrs] packet presented to nodes
module bus_gnrtr_n_rbtr
  import bs_pkg::*;
#(
  parameter int unsigned     bits      = 1,
  parameter int unsigned     drvrs     = 4,
  parameter int unsigned     pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [bits-1:0][drvrs-1:0]             pndng,
  output logic [bits-1:0][drvrs-1:0]             push,
  output logic [bits-1:0][drvrs-1:0]             pop,
  input  logic [pckg_sz-1:0][bits-1:0][drvrs-1:0] D_pop,
  output logic [pckg_sz-1:0][bits-1:0][drvrs-1:0] D_push
);

  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] w_dpop;
  logic [bits-1:0][pckg_sz-1:0]            w_dpush;

  // External buses are bit-major; lanes want one packet vector per node.
  always_comb begin
    w_dpop = '0;
    for (int unsigned l = 0; l < bits; l++)
      for (int unsigned n = 0; n < drvrs; n++)
        for (int unsigned b = 0; b < pckg_sz; b++)
          w_dpop[l][n][b] = D_pop[b][l][n];
  end

  always_comb begin
    D_push = '0;
    for (int unsigned l = 0; l < bits; l++)
      for (int unsigned n = 0; n < drvrs; n++)
        for (int unsigned b = 0; b < pckg_sz; b++)
          D_push[b][l][n] = w_dpush[l][b];
  end

  for (genvar l = 0; l < bits; l++) begin : g_lane
    bs_rbtr_lane #(
      .drvrs     (drvrs),
      .pckg_sz   (pckg_sz),
      .broadcast (broadcast)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .pndng  (pndng[l]),
      .D_pop  (w_dpop[l]),
      .pop    (pop[l]),
      .push   (push[l]),
      .D_push (w_dpush[l])
    );
  end

endmodule

// File: tb/tb_bus_gnrtr_n_rbtr.sv
module tb_bus_gnrtr_n_rbtr;

  localparam int unsigned DRV = 4;
  localparam int unsigned PSZ = 8;

`ifdef BS_BROADCAST_SELF_EN
  localparam logic [DRV-1:0] BC_EXP = 4'b1111;
`else
  localparam logic [DRV-1:0] BC_EXP = 4'b1011;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [0:0][DRV-1:0]          pndng, push, pop;
  logic [PSZ-1:0][0:0][DRV-1:0] D_pop, D_push;
  logic [PSZ-1:0]               pkt [DRV];
  logic [DRV-1:0]               rr_push [DRV];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus_gnrtr_n_rbtr #(
    .bits      (1),
    .drvrs     (DRV),
    .pckg_sz   (PSZ),
    .broadcast (8'hFF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .push   (push),
    .pop    (pop),
    .D_pop  (D_pop),
    .D_push (D_push)
  );

  always_comb begin
    D_pop = '0;
    for (int n = 0; n < DRV; n++)
      for (int b = 0; b < PSZ; b++)
        D_pop[b][0][n] = pkt[n][b];
  end

  function automatic logic [PSZ-1:0] dpush_of(input int n);
    logic [PSZ-1:0] v;
    for (int b = 0; b < PSZ; b++) v[b] = D_push[b][0][n];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pop"},  32'(pop[0]),  32'h0);
    chk({tag, "_push"}, 32'(push[0]), 32'h0);
  endtask

  initial begin
    rr_push[0] = 4'b0010;
    rr_push[1] = 4'b0001;
    rr_push[2] = 4'b1000;
    rr_push[3] = 4'b0100;
    pkt[0] = 8'h01; pkt[1] = 8'h00; pkt[2] = 8'h03; pkt[3] = 8'h02;
    reset = 1'b1;
    pndng = '1;

    // Reset held with everything pending: no activity.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("rst_hold");
      chk("rst_dpush", 32'(D_push), 32'h0);
    end
    reset = 1'b0;

    // Round-robin straight out of reset: pops 0,1,2,3, 3 cycles each.
    for (int k = 0; k < DRV; k++) begin
      @(negedge clk);
      chk("rr_pop",      32'(pop[0]),  32'(4'b0001 << k));
      chk("rr_pop_push", 32'(push[0]), 32'h0);
      @(negedge clk);
      chk("rr_push",     32'(push[0]), 32'(rr_push[k]));
      chk("rr_push_pop", 32'(pop[0]),  32'h0);
      chk("rr_dpush",    32'(dpush_of(k)), 32'(pkt[k]));
      pndng[0][k] = 1'b0;
      @(negedge clk);
      chk_idle("rr_idle");
    end
    @(negedge clk);
    chk_idle("rr_done");

    // Unicast node 0 -> node 1.
    pkt[0] = 8'h01; pndng[0] = 4'b0001;
    @(negedge clk);
    chk("uc_pop", 32'(pop[0]), 32'h1);
    @(negedge clk);
    chk("uc_push",  32'(push[0]), 32'h2);
    chk("uc_dpush", 32'(dpush_of(1)), 32'h01);
    pndng[0] = '0;
    @(negedge clk);
    chk_idle("uc_idle");

    // Broadcast from node 2.
    pkt[2] = 8'hFF; pndng[0] = 4'b0100;
    @(negedge clk);
    chk("bc_pop", 32'(pop[0]), 32'h4);
    @(negedge clk);
    chk("bc_push",  32'(push[0]), 32'(BC_EXP));
    chk("bc_dpush", 32'(dpush_of(3)), 32'hFF);
    pndng[0] = '0;
    @(negedge clk);
    chk_idle("bc_idle");

    // Invalid destination from node 1: popped, dropped, D_push holds FF.
    pkt[1] = 8'h05; pndng[0] = 4'b0010;
    @(negedge clk);
    chk("inv_pop", 32'(pop[0]), 32'h2);
    @(negedge clk);
    chk("inv_push",  32'(push[0]), 32'h0);
    chk("inv_dpush", 32'(dpush_of(0)), 32'hFF);
    pndng[0] = '0;
    @(negedge clk);
    chk_idle("inv_idle");
    chk("inv_hold", 32'(dpush_of(2)), 32'hFF);

    // Reset during PUSH: strobes drop at once, packet lost.
    pkt[3] = 8'h02; pndng[0] = 4'b1000;
    @(negedge clk);
    chk("mr_pop", 32'(pop[0]), 32'h8);
    @(negedge clk);
    chk("mr_push", 32'(push[0]), 32'h4);
    pndng[0] = '0;
    #1 reset = 1'b1;
    #1;
    chk_idle("mr_async");
    chk("mr_dpush", 32'(dpush_of(2)), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("mr_after");
    chk("mr_after_dpush", 32'(dpush_of(0)), 32'h0);

    // Arbitration restarts at node 0.
    pkt[0] = 8'h03; pndng[0] = 4'b1111;
    @(negedge clk);
    chk("mr_pop0", 32'(pop[0]), 32'h1);
    @(negedge clk);
    chk("mr_push0",  32'(push[0]), 32'h8);
    chk("mr_dpush0", 32'(dpush_of(3)), 32'h03);

    reset = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
